gate_exerciser: RTL

GATE_EXERCISER -- requirements
Module: gate_exerciser

---
 rtl/gate_pkg.sv | 22 ++
 rtl/gate_ref.sv | 22 ++
 rtl/gate_exerciser.sv | 94 +++++++++
 3 files changed

// File: rtl/gate_pkg.sv
// Shared definitions for the gate exerciser: FSM encoding, gate bit positions
// within the 7-bit result vector, and the exhaustive two-input vector count.
package gate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int AND_IDX   = 0;
  localparam int OR_IDX    = 1;
  localparam int NOT_IDX   = 2;
  localparam int XOR_IDX   = 3;
  localparam int NAND_IDX  = 4;
  localparam int NOR_IDX   = 5;
  localparam int XNOR_IDX  = 6;
  localparam int NUM_GATES = 7;
  localparam int NUM_VEC   = 4;

endpackage

// File: rtl/gate_ref.sv
// Golden combinational model of the seven gates under test; produces the
// expected result vector for the current {a,b} stimulus.
module gate_ref
  import gate_pkg::*;
(
  input  logic                 i_a,
  input  logic                 i_b,
  output logic [NUM_GATES-1:0] o_exp
);

  always_comb begin
    o_exp           = '0;
    o_exp[AND_IDX]  = i_a & i_b;
    o_exp[OR_IDX]   = i_a | i_b;
    o_exp[NOT_IDX]  = ~i_a;
    o_exp[XOR_IDX]  = i_a ^ i_b;
    o_exp[NAND_IDX] = ~(i_a & i_b);
    o_exp[NOR_IDX]  = ~(i_a | i_b);
    o_exp[XNOR_IDX] = ~(i_a ^ i_b);
  end

endmodule

// File: rtl/gate_exerciser.sv
// Walks {a,b} through all four vectors, lets the gates settle, and compares
// the observed outputs against gate_ref, collecting a sticky mismatch mask.
module gate_exerciser
  import gate_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] fail_mask,
  output logic [1:0] first_fail_vec
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [1:0] LAST_IDX = 2'(NUM_VEC - 1);

  state_t     r_state, w_next;
  logic [3:0] r_cnt;
  logic [1:0] r_idx;
  logic [6:0] r_fail_mask;
  logic [1:0] r_ffv;
  logic       r_pass;
  logic [6:0] w_exp;
  logic [6:0] w_mm;

  gate_ref u_ref (
    .i_a   (r_idx[1]),
    .i_b   (r_idx[0]),
    .o_exp (w_exp)
  );

  assign w_mm = y ^ w_exp;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_SETTLE;
      ST_SETTLE: if (r_cnt == 4'd0) w_next = ST_CHECK;
      ST_CHECK:  w_next = (r_idx == LAST_IDX) ? ST_DONE : ST_SETTLE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_fail_mask <= '0;
      r_ffv       <= '0;
      r_pass      <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: if (start) begin
          r_idx       <= '0;
          r_cnt       <= CNT_LOAD;
          r_fail_mask <= '0;
          r_ffv       <= '0;
          r_pass      <= 1'b0;
        end
        ST_SETTLE: if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        ST_CHECK: begin
          r_fail_mask <= r_fail_mask | w_mm;
          // An all-zero mask so far means this is the first failing vector.
          if (w_mm != '0 && r_fail_mask == '0) r_ffv <= r_idx;
          // Index wraps 3->0, so {a,b} is back at 00 by the time IDLE is reached.
          r_idx <= r_idx + 2'd1;
          r_cnt <= CNT_LOAD;
          // Resolve pass on entry to DONE so it is valid alongside the done pulse.
          if (r_idx == LAST_IDX) r_pass <= ((r_fail_mask | w_mm) == '0);
        end
        default: ;
      endcase
    end
  end

  assign a              = r_idx[1];
  assign b              = r_idx[0];
  assign busy           = (r_state != ST_IDLE);
  assign done           = (r_state == ST_DONE);
  assign pass           = r_pass;
  assign fail_mask      = r_fail_mask;
  assign first_fail_vec = r_ffv;

endmodule
